// File: rtl/easy_cpu_debug_pkg.sv
// +-----------------------------------------------------------------------+
// | easy_cpu_debug_pkg : shared constants for the OCI memory debug port   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package easy_cpu_debug_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    OCI_IDLE = ST_IDLE,
    OCI_RD   = ST_RD,
    OCI_WR   = ST_WR,
    OCI_DONE = ST_DONE
  } ocimem_state_e;

  localparam int JDO_ADDR_LSB    = 3;
  localparam int JDO_RD_BIT      = 17;
  localparam int JDO_DATA_MSB    = 34;
  localparam int JDO_DATA_LSB    = 3;
  localparam int TIMEOUT_DEFAULT = 256;

endpackage

`default_nettype wire

// File: rtl/easy_cpu_debug_ocimem_timeout.sv
// +-----------------------------------------------------------------------+
// | easy_cpu_debug_ocimem_timeout : consecutive-stall counter, built only |
// | with DEBUG_OCIMEM_TIMEOUT_EN.  Rev 1.0                                |
// +-----------------------------------------------------------------------+
`default_nettype none

`ifdef DEBUG_OCIMEM_TIMEOUT_EN
module easy_cpu_debug_ocimem_timeout
  import easy_cpu_debug_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // expired fires on the TIMEOUT_CYCLES-th consecutive stalled edge
  assign expired = start && !clear && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (start) begin
      count_d = expired ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/easy_cpu_cpu_debug_ocimem_ctrl.sv
// +-----------------------------------------------------------------------+
// | easy_cpu_cpu_debug_ocimem_ctrl : JTAG-driven OCI memory access FSM;   |
// | optional stall abort via DEBUG_OCIMEM_TIMEOUT_EN.  Rev 1.0            |
// +-----------------------------------------------------------------------+
`default_nettype none

module easy_cpu_cpu_debug_ocimem_ctrl
  import easy_cpu_debug_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic              any_strobe;
  logic              req_active;
  logic              stall;
  logic              expired;
  logic              unused_ok;

  assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign req_active = (state_q == ST_RD) || (state_q == ST_WR);
  assign stall      = req_active && mem_waitrequest;
  assign unused_ok  = ^{jdo[37:35], jdo[2:0], 1'(TIMEOUT_CYCLES > 0)};

`ifdef DEBUG_OCIMEM_TIMEOUT_EN
  easy_cpu_debug_ocimem_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (stall),
    .clear   (!stall),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (take_action_ocimem_b) begin
          data_d  = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
          state_d = ST_WR;
        end else if (take_action_ocimem_a) begin
          addr_d = jdo[JDO_ADDR_LSB +: ADDR_W];
          err_d  = 1'b0;
          if (jdo[JDO_RD_BIT]) begin
            state_d = ST_RD;
          end
        end else if (take_no_action_ocimem_a) begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (any_strobe) err_d = 1'b1;
        if (expired) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (!mem_waitrequest) begin
          data_d  = mem_readdata;
          state_d = ST_DONE;
        end
      end
      ST_WR: begin
        if (any_strobe) err_d = 1'b1;
        if (expired) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (!mem_waitrequest) begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_DONE;
        end
      end
      default: begin
        if (any_strobe) err_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // async reset drops the bus strobes immediately since they decode state_q
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign mem_read      = (state_q == ST_RD);
  assign mem_write     = (state_q == ST_WR);
  assign mem_address   = addr_q;
  assign mem_writedata = data_q;
  assign MonDReg       = data_q;
  assign monitor_ready = (state_q == ST_IDLE);
  assign monitor_error = err_q;

endmodule

`default_nettype wire

// File: tb/tb_easy_cpu_cpu_debug_ocimem_ctrl.sv
// +-----------------------------------------------------------------------+
// | tb_easy_cpu_cpu_debug_ocimem_ctrl : scoreboard bench with a          |
// | transaction-level model of the debug memory port.  Rev 1.0           |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_easy_cpu_cpu_debug_ocimem_ctrl;

  localparam int ADDR_W = 8;
  localparam int TO     = 256;
`ifdef DEBUG_OCIMEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        sa, sna, sb;
  logic [7:0]  mem_address;
  logic        mem_read, mem_write;
  logic [31:0] mem_writedata, mem_readdata;
  logic        mem_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  easy_cpu_cpu_debug_ocimem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (sa),
    .take_no_action_ocimem_a (sna),
    .take_action_ocimem_b    (sb),
    .mem_address             (mem_address),
    .mem_read                (mem_read),
    .mem_write               (mem_write),
    .mem_writedata           (mem_writedata),
    .mem_readdata            (mem_readdata),
    .mem_waitrequest         (mem_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit is_wr; logic [7:0] addr; logic [31:0] data; } bus_t;
  typedef struct { logic [31:0] data; bit err; int cyc; } done_t;
  bus_t  bus_q[$];
  done_t done_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // reference state: address register, data register, sticky error
  logic [7:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  bit          m_err  = 1'b0;
  int          stall_left = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // memory responder: stalls the active request for stall_left cycles
  always @(posedge clk) begin
    #2;
    if (reset_n && (mem_read || mem_write) && stall_left > 0) begin
      mem_waitrequest = 1'b1;
      stall_left--;
    end else begin
      mem_waitrequest = 1'b0;
    end
  end

  // monitor: bus acceptances and command completions
  bit prev_ready = 1'b1;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_ready = 1'b1;
    end else begin
      if (mem_read || mem_write) check("rd_wr_exclusive", 64'(mem_read & mem_write), 64'd0);
      if ((mem_read || mem_write) && !mem_waitrequest) begin
        if (bus_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL bus_unexpected: got access at 0x%0h, expected none", mem_address);
        end else begin
          bus_t b;
          b = bus_q.pop_front();
          check("bus_kind", 64'(mem_write), 64'(b.is_wr));
          check("bus_addr", 64'(mem_address), 64'(b.addr));
          if (b.is_wr) check("bus_wdata", 64'(mem_writedata), 64'(b.data));
        end
      end
      if (!prev_ready && monitor_ready) begin
        if (done_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL done_unexpected: got completion, expected none");
        end else begin
          done_t d;
          d = done_q.pop_front();
          check("done_mondreg", 64'(MonDReg), 64'(d.data));
          check("done_error", 64'(monitor_error), 64'(d.err));
          check("done_latency", 64'(cyc), 64'(d.cyc));
        end
      end
      prev_ready = monitor_ready;
    end
  end

  task automatic issue(input bit a, input bit na, input bit b, input logic [37:0] j,
                       input int stall, input logic [31:0] rd, input bit collide);
    bit busy, aborted;
    int c, n;
    logic [63:0] r;
    tick();
    jdo = j; sa = a; sna = na; sb = b;
    mem_readdata = rd;
    stall_left = stall;
    c = cyc;
    busy = 1'b0;
    aborted = TO_EN && (stall >= TO);
    if (b) begin
      busy = 1'b1;
      m_data = j[34:3];
      if (aborted) m_err = 1'b1;
      else begin
        bus_q.push_back('{1'b1, m_addr, m_data});
        m_addr = m_addr + 8'd1;
      end
    end else if (a || na) begin
      if (a) begin
        m_addr = j[10:3];
        m_err  = 1'b0;
        busy   = j[17];
      end else begin
        m_addr = m_addr + 8'd1;
        busy   = 1'b1;
      end
      if (busy) begin
        if (aborted) m_err = 1'b1;
        else begin
          bus_q.push_back('{1'b0, m_addr, rd});
          m_data = rd;
        end
      end
    end
    if (collide && busy) m_err = 1'b1;
    if (busy) done_q.push_back('{m_data, m_err, aborted ? c + TO + 2 : c + 3 + stall});
    tick();
    sa = 1'b0; sna = 1'b0; sb = 1'b0;
    if (collide && busy) begin
      r = {$urandom, $urandom};
      jdo = r[37:0];
      case ($urandom_range(0, 2))
        0: sa = 1'b1;
        1: sna = 1'b1;
        default: sb = 1'b1;
      endcase
      tick();
      sa = 1'b0; sna = 1'b0; sb = 1'b0;
    end
    if (busy) begin
      n = 0;
      while (!monitor_ready && n < TO + 50) begin
        tick();
        n++;
      end
      if (!monitor_ready) begin
        n_checks++;
        n_fail++;
        $display("FAIL ready_timeout: got monitor_ready=0, expected 1 within %0d cycles", TO + 50);
      end
    end
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] addr, input bit rdnow);
    logic [37:0] j;
    j = '0;
    j[10:3] = addr;
    j[17] = rdnow;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    return {3'b000, d, 3'b000};
  endfunction

  initial begin
    logic [63:0] r;
    logic [2:0]  v;
    jdo = '0; sa = 0; sna = 0; sb = 0;
    mem_readdata = '0; mem_waitrequest = 0;
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_ready", 64'(monitor_ready), 64'd1);
    check("rst_error", 64'(monitor_error), 64'd0);
    check("rst_mondreg", 64'(MonDReg), 64'd0);
    check("rst_read", 64'(mem_read), 64'd0);
    check("rst_write", 64'(mem_write), 64'd0);
    check("rst_addr", 64'(mem_address), 64'd0);
    reset_n = 1'b1;

    // load-and-read, write with stall, write to incremented address
    issue(1, 0, 0, jdo_a(8'h10, 1), 0, 32'hDEADBEEF, 0);
    issue(1, 0, 0, jdo_a(8'h20, 0), 0, 32'h0, 0);
    issue(0, 0, 1, jdo_b(32'h12345678), 4, 32'h0, 0);
    issue(0, 0, 1, jdo_b(32'hCAFEF00D), 0, 32'h0, 0);
    // wrap from all-ones
    issue(1, 0, 0, jdo_a(8'hFF, 1), 1, 32'h0BADF00D, 0);
    issue(0, 1, 0, 38'h0, 0, 32'h11223344, 0);
    // busy collision, then cleared by the next load
    issue(1, 0, 0, jdo_a(8'h40, 1), 2, 32'hA5A5A5A5, 1);
    issue(1, 0, 0, jdo_a(8'h41, 1), 0, 32'h5A5A5A5A, 0);
    // simultaneous strobes
    issue(1, 1, 1, jdo_b(32'h87654321), 0, 32'h0, 0);
    issue(1, 1, 0, jdo_a(8'h80, 1), 0, 32'h13579BDF, 0);
`ifdef DEBUG_OCIMEM_TIMEOUT_EN
    issue(1, 0, 0, jdo_a(8'h55, 1), TO + 5, 32'hFFFF0000, 0);
    issue(0, 0, 1, jdo_b(32'h0F0F0F0F), TO + 5, 32'h0, 0);
    issue(1, 0, 0, jdo_a(8'h56, 1), 0, 32'h00C0FFEE, 0);
`endif

    // reset in the middle of a stalled write
    tick();
    jdo = jdo_b(32'hFEEDFACE); sb = 1'b1; stall_left = 5;
    tick();
    sb = 1'b0;
    check("midwr_active", 64'(mem_write), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midwr_write_drop", 64'(mem_write), 64'd0);
    check("midwr_read", 64'(mem_read), 64'd0);
    check("midwr_mondreg", 64'(MonDReg), 64'd0);
    check("midwr_ready", 64'(monitor_ready), 64'd1);
    tick();
    reset_n = 1'b1;
    m_addr = '0; m_data = '0; m_err = 1'b0;
    issue(0, 0, 1, jdo_b(32'h600DCAFE), 0, 32'h0, 0);

    for (int i = 0; i < 60; i++) begin
      v = 3'($urandom_range(1, 7));
      r = {$urandom, $urandom};
      issue(v[0], v[1], v[2], r[37:0], int'($urandom_range(0, 5)), $urandom,
            ($urandom_range(0, 4) == 0));
    end

    repeat (4) tick();
    check("bus_queue_empty", 64'(bus_q.size()), 64'd0);
    check("done_queue_empty", 64'(done_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/easy_cpu_cpu_debug_ocimem_ctrl.md
EASY_CPU_CPU_DEBUG_OCIMEM_CTRL -- requirements
Module: easy_cpu_cpu_debug_ocimem_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning OCI memory word-address width.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 256, meaning the maximum number of cycles a memory request may stall.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: clk in 1, the system clock; reset_n in 1, the async active-low reset.
REQ-004 Command ports SHALL be: jdo in 38, the JTAG data word; take_action_ocimem_a in 1, load address; take_no_action_ocimem_a in 1, increment-and-read; take_action_ocimem_b in 1, write data.
REQ-005 Memory ports SHALL be: mem_address out ADDR_W; mem_read out 1; mem_write out 1; mem_writedata out 32; mem_readdata in 32; mem_waitrequest in 1.
REQ-006 Status ports SHALL be: MonDReg out 32, the monitor data register; monitor_ready out 1, idle/complete; monitor_error out 1, sticky error.

Function
REQ-007 The FSM SHALL have the states IDLE, RD, WR, and DONE.
REQ-008 take_action_ocimem_a in IDLE: MonAReg <= jdo[ADDR_W+2:3]; if jdo[17]=1 go to RD, else stay in IDLE; monitor_error <= 0.
REQ-009 take_no_action_ocimem_a in IDLE: MonAReg <= MonAReg+1 (wrapping at all-ones to 0), then go to RD.
REQ-010 take_action_ocimem_b in IDLE: MonDReg <= jdo[34:3], then go to WR.
REQ-011 Strobe priority on the same cycle SHALL be ocimem_b > ocimem_a > no_action_a; the lower-priority strobes are ignored without error.
REQ-012 RD behaviour: mem_read=1 and mem_address=MonAReg, held stable while mem_waitrequest=1; on the first edge with waitrequest=0, MonDReg <= mem_readdata and go to DONE.
REQ-013 WR behaviour: mem_write=1 and mem_writedata=MonDReg, held stable while waitrequest=1; on acceptance, MonAReg <= MonAReg+1 (wrapping) and go to DONE.
REQ-014 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-015 Minimum latency from strobe to monitor_ready=1 SHALL be 3 cycles (strobe edge, request edge, DONE edge).
REQ-016 monitor_ready SHALL be 1 only in IDLE; it deasserts the cycle after an accepted command.
REQ-017 Any strobe arriving outside IDLE SHALL be ignored, and SHALL set monitor_error=1 (sticky until the next accepted take_action_ocimem_a).
REQ-018 mem_read and mem_write SHALL never be asserted together.

Reset
REQ-019 Reset SHALL force state=IDLE, MonAReg=0, MonDReg=0, mem_read=0, mem_write=0, monitor_ready=1, monitor_error=0, and the timeout count=0.
REQ-020 Reset mid-transaction SHALL drop mem_read/mem_write asynchronously; no address increment occurs.

Configuration
REQ-021 With DEBUG_OCIMEM_TIMEOUT_EN defined: a request stalled for TIMEOUT_CYCLES consecutive cycles SHALL abort with mem_read/mem_write=0, monitor_error=1, MonDReg unchanged, no increment, and a transition to DONE.
REQ-022 Without DEBUG_OCIMEM_TIMEOUT_EN: there is no counter, and requests wait indefinitely.

Structure
REQ-023 Package easy_cpu_debug_pkg SHALL hold the FSM state enum, the jdo field constants (address LSB 3, read-now bit 17, data 34:3), and the TIMEOUT default.
REQ-024 The timeout counter SHALL be sub-module easy_cpu_debug_ocimem_timeout (start, clear, expired), instantiated only under DEBUG_OCIMEM_TIMEOUT_EN.

Verification
REQ-025 Load and read: ocimem_a with jdo address 0x10 and bit17=1, waitrequest=0, readdata=0xDEADBEEF -> mem_read for 1 cycle at 0x10; MonDReg=0xDEADBEEF; monitor_ready=1 three cycles after the strobe.
REQ-026 Write then increment: ocimem_b with data 0x12345678 at address 0x20, waitrequest=1 for 4 cycles -> mem_write held for 5 cycles; MonAReg=0x21 afterwards.
REQ-027 Wrap: MonAReg=0xFF then no_action_a -> read issued at address 0x00.
REQ-028 Busy collision: ocimem_b issued during RD -> ignored; monitor_error=1; the next ocimem_a clears it.
REQ-029 Timeout (macro on): waitrequest stuck at 1 -> abort after 256 cycles; monitor_error=1; monitor_ready=1.
REQ-030 Reset mid-WR: reset_n=0 while mem_write=1 -> mem_write=0 immediately; MonAReg=0.
